keypad_scanner: RTL

//   Scans a 5-row x 4-column active-low key matrix, synchronises and debounces it,
//   and produces the one-cycle key-event pulses that the calculator control FSM consumes.

---
 rtl/keypad_scanner.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// Row-scanning, debouncing 5x4 keypad front end for the calculator control FSM.
// Produces one single-cycle event pulse per accepted key press, with no auto-repeat.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [4:0] row_n,
    output logic       dig_in,
    output logic       op_in,
    output logic       ex_in,
    output logic       bksp_in,
    output logic       reset_in,
    output logic       MS_in,
    output logic       MR_in,
    output logic       MC_in,
    output logic [3:0] digit,
    output logic [1:0] op_code,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [3:0]    col_meta_r;
    logic [3:0]    col_sync_r;
    logic [2:0]    row_r;
    logic [DW-1:0] dwell_r;
    logic [1:0]    acc_cnt_r;
    logic [4:0]    acc_idx_r;
    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [CW-1:0] cnt_inc_s;
    logic [4:0]    cand_r;
    logic [4:0]    cand_s;
    logic          key_held_s;
    logic          emit_s;
    logic          sample_s;
    logic          frame_done_s;
    logic [3:0]    hits_s;
    logic [1:0]    row_cnt_s;
    logic [1:0]    row_col_s;
    logic [1:0]    base_cnt_s;
    logic [4:0]    base_idx_s;
    logic [2:0]    sum_s;
    logic [1:0]    frame_cnt_s;
    logic [4:0]    frame_idx_s;
    logic          is_none_s;
    logic          is_key_s;

    assign sample_s     = (dwell_r == DW'(SCAN_DIV - 1));
    assign frame_done_s = sample_s && (row_r == 3'd4);
    assign hits_s       = ~col_sync_r;
    assign is_none_s    = (frame_cnt_s == 2'd0);
    assign is_key_s     = (frame_cnt_s == 2'd1);
    assign cnt_inc_s    = (cnt_r == CW'(DEBOUNCE_SCANS)) ? cnt_r : cnt_r + CW'(1);

    // Two-flop synchroniser for the asynchronous column inputs
    always_ff @(posedge clock) begin
        if (reset) begin
            col_meta_r <= 4'hF;
            col_sync_r <= 4'hF;
        end else begin
            col_meta_r <= col_n;
            col_sync_r <= col_meta_r;
        end
    end

    // Free-running dwell/row counters and one-hot active-low row drive
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell_r <= '0;
            row_r   <= 3'd0;
            row_n   <= 5'b11110;
        end else if (sample_s) begin
            dwell_r <= '0;
            row_r   <= (row_r == 3'd4) ? 3'd0 : row_r + 3'd1;
            row_n   <= (row_r == 3'd4) ? 5'b11110 : {row_n[3:0], row_n[4]};
        end else begin
            dwell_r <= dwell_r + DW'(1);
        end
    end

    // Classify this row's columns and fold them into the running frame code (count saturates at 2)
    always_comb begin
        row_cnt_s = 2'd0;
        row_col_s = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (hits_s[c]) begin
                row_cnt_s = (row_cnt_s == 2'd2) ? 2'd2 : row_cnt_s + 2'd1;
                row_col_s = 2'(c);
            end else begin
                row_cnt_s = row_cnt_s;
            end
        end
        base_cnt_s  = (row_r == 3'd0) ? 2'd0 : acc_cnt_r;
        base_idx_s  = (row_r == 3'd0) ? 5'd0 : acc_idx_r;
        sum_s       = {1'b0, base_cnt_s} + {1'b0, row_cnt_s};
        frame_cnt_s = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        frame_idx_s = (row_cnt_s == 2'd1) ? ({row_r[2:0], 2'b00} + {3'b000, row_col_s}) : base_idx_s;
    end

    // Frame code accumulator, updated at every row sample
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_cnt_r <= 2'd0;
            acc_idx_r <= 5'd0;
        end else if (sample_s) begin
            acc_cnt_r <= frame_cnt_s;
            acc_idx_r <= frame_idx_s;
        end else begin
            acc_cnt_r <= acc_cnt_r;
            acc_idx_r <= acc_idx_r;
        end
    end

    // Debounce FSM state register; reset waits for a release so a key held through reset is ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= RELEASE_WAIT;
            cnt_r    <= '0;
            cand_r   <= 5'd0;
            key_held <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            cand_r   <= cand_s;
            key_held <= key_held_s;
        end
    end

    // Debounce FSM next-state logic, evaluated once per completed frame
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        cand_s     = cand_r;
        key_held_s = key_held;
        emit_s     = 1'b0;
        if (frame_done_s) begin
            case (state_r)
                IDLE: begin
                    if (is_key_s) begin
                        cand_s = frame_idx_s;
                        cnt_s  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            emit_s     = 1'b1;
                            key_held_s = 1'b1;
                            state_s    = HELD;
                        end else begin
                            state_s = PRESS_WAIT;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (is_key_s && (frame_idx_s == cand_r)) begin
                        cnt_s = cnt_inc_s;
                        if (cnt_inc_s == CW'(DEBOUNCE_SCANS)) begin
                            emit_s     = 1'b1;
                            key_held_s = 1'b1;
                            state_s    = HELD;
                        end else begin
                            state_s = PRESS_WAIT;
                        end
                    end else begin
                        cnt_s   = '0;
                        state_s = IDLE;
                    end
                end
                HELD: begin
                    if (is_none_s) begin
                        cnt_s = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            key_held_s = 1'b0;
                            state_s    = IDLE;
                        end else begin
                            state_s = RELEASE_WAIT;
                        end
                    end else begin
                        state_s = HELD;
                    end
                end
                RELEASE_WAIT: begin
                    if (is_none_s) begin
                        cnt_s = cnt_inc_s;
                        if (cnt_inc_s == CW'(DEBOUNCE_SCANS)) begin
                            key_held_s = 1'b0;
                            state_s    = IDLE;
                        end else begin
                            state_s = RELEASE_WAIT;
                        end
                    end else begin
                        cnt_s   = '0;
                        state_s = HELD;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Registered event pulses and held data values, decoded from the key map
    always_ff @(posedge clock) begin
        if (reset) begin
            dig_in   <= 1'b0;
            op_in    <= 1'b0;
            ex_in    <= 1'b0;
            bksp_in  <= 1'b0;
            reset_in <= 1'b0;
            MS_in    <= 1'b0;
            MR_in    <= 1'b0;
            MC_in    <= 1'b0;
            digit    <= 4'd0;
            op_code  <= 2'd0;
        end else begin
            dig_in   <= 1'b0;
            op_in    <= 1'b0;
            ex_in    <= 1'b0;
            bksp_in  <= 1'b0;
            reset_in <= 1'b0;
            MS_in    <= 1'b0;
            MR_in    <= 1'b0;
            MC_in    <= 1'b0;
            if (emit_s) begin
                case (cand_s)
                    5'd0:  begin dig_in <= 1'b1; digit <= 4'd1; end
                    5'd1:  begin dig_in <= 1'b1; digit <= 4'd2; end
                    5'd2:  begin dig_in <= 1'b1; digit <= 4'd3; end
                    5'd3:  begin op_in  <= 1'b1; op_code <= 2'b00; end
                    5'd4:  begin dig_in <= 1'b1; digit <= 4'd4; end
                    5'd5:  begin dig_in <= 1'b1; digit <= 4'd5; end
                    5'd6:  begin dig_in <= 1'b1; digit <= 4'd6; end
                    5'd7:  begin op_in  <= 1'b1; op_code <= 2'b01; end
                    5'd8:  begin dig_in <= 1'b1; digit <= 4'd7; end
                    5'd9:  begin dig_in <= 1'b1; digit <= 4'd8; end
                    5'd10: begin dig_in <= 1'b1; digit <= 4'd9; end
                    5'd11: begin op_in  <= 1'b1; op_code <= 2'b10; end
                    5'd12: bksp_in  <= 1'b1;
                    5'd13: begin dig_in <= 1'b1; digit <= 4'd0; end
                    5'd14: ex_in    <= 1'b1;
                    5'd15: begin op_in  <= 1'b1; op_code <= 2'b11; end
                    5'd16: reset_in <= 1'b1;
                    5'd17: MS_in    <= 1'b1;
                    5'd18: MR_in    <= 1'b1;
                    5'd19: MC_in    <= 1'b1;
                    default: dig_in <= 1'b0;
                endcase
            end else begin
                digit <= digit;
            end
        end
    end

endmodule
